panel_switch_conditioner: RTL

Front-panel switch conditioner sitting directly upstream of the CPU's switch inputs. Takes the five raw, bouncing, asynchronous, active-low panel buttons from the board pins. Produces clean, SYSCLK-synchronous controls for the CPU:
- one-cycle pulses for CLEAR, RUN, STEPM and STEPI;
- a debounced level for HALT.

---
 rtl/panel_switch_conditioner.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/panel_switch_conditioner.sv
// panel_switch_conditioner: synchronizes and debounces the five active-low
// front-panel buttons into clean SYSCLK-domain controls for the CPU.
// Ports: SYSCLK, RESET (async, active-high), raw_*_n (raw buttons),
//   sw_CLEAR/sw_RUN/sw_STEPM/sw_STEPI (one-cycle press pulses),
//   sw_HALT (debounced level).
// Option: define PANEL_AUTOREPEAT_EN for STEPI auto-repeat while held.
module panel_switch_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_CYCLES   = 2000000
) (
  input  logic SYSCLK,
  input  logic RESET,
  input  logic raw_CLEAR_n,
  input  logic raw_RUN_n,
  input  logic raw_HALT_n,
  input  logic raw_STEPM_n,
  input  logic raw_STEPI_n,
  output logic sw_CLEAR,
  output logic sw_RUN,
  output logic sw_HALT,
  output logic sw_STEPM,
  output logic sw_STEPI
);

  localparam int CLR = 0;
  localparam int RUN = 1;
  localparam int HLT = 2;
  localparam int STM = 3;
  localparam int STI = 4;

  localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [4:0]       raw_n;
  logic [4:0]       s1_q;
  logic [4:0]       s2_q;
  logic [4:0]       pressed_sync;
  logic [4:0]       db_q;
  logic [4:0]       db_d;
  logic [4:0][15:0] cnt_q;
  logic [4:0][15:0] cnt_d;
  logic [4:0]       rise;
  logic             clr_block;
  logic             rep_fire;

  logic clear_q, clear_d;
  logic run_q, run_d;
  logic halt_q, halt_d;
  logic stepm_q, stepm_d;
  logic stepi_q, stepi_d;

  assign raw_n = {raw_STEPI_n, raw_STEPM_n,
                  raw_HALT_n, raw_RUN_n, raw_CLEAR_n};

  assign pressed_sync = ~s2_q;

  always_comb begin
    db_d  = db_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (pressed_sync[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DB_LAST) begin
        db_d[i]  = pressed_sync[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + 16'd1;
      end
    end
  end

  assign rise = db_d & ~db_q;

  // CLEAR held (or just pressed/released this edge) swallows other presses.
  assign clr_block = db_q[CLR] | db_d[CLR];

`ifdef PANEL_AUTOREPEAT_EN
  localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);

  logic [23:0] rep_q;
  logic [23:0] rep_d;

  // Counts only while STEPI stays held; press edge and release give 0.
  always_comb begin
    rep_d    = '0;
    rep_fire = 1'b0;
    if (db_q[STI] && db_d[STI]) begin
      if (rep_q == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_d = rep_q + 24'd1;
      end
    end
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) rep_q <= '0;
    else       rep_q <= rep_d;
  end
`else
  logic [23:0] rep_unused;
  assign rep_unused = 24'(REPEAT_CYCLES);
  assign rep_fire   = 1'b0;
`endif

  always_comb begin
    clear_d = rise[CLR];
    run_d   = rise[RUN] & ~clr_block;
    halt_d  = db_d[HLT];
    stepm_d = rise[STM] & ~clr_block;
    stepi_d = (rise[STI] | rep_fire) & ~clr_block;
  end

  always_ff @(posedge SYSCLK or posedge RESET) begin
    if (RESET) begin
      s1_q    <= '1;
      s2_q    <= '1;
      db_q    <= '0;
      cnt_q   <= '0;
      clear_q <= 1'b0;
      run_q   <= 1'b0;
      halt_q  <= 1'b0;
      stepm_q <= 1'b0;
      stepi_q <= 1'b0;
    end else begin
      s1_q    <= raw_n;
      s2_q    <= s1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      clear_q <= clear_d;
      run_q   <= run_d;
      halt_q  <= halt_d;
      stepm_q <= stepm_d;
      stepi_q <= stepi_d;
    end
  end

  assign sw_CLEAR = clear_q;
  assign sw_RUN   = run_q;
  assign sw_HALT  = halt_q;
  assign sw_STEPM = stepm_q;
  assign sw_STEPI = stepi_q;

endmodule
